// File: rtl/global_types.sv
// -----------------------------------------------------------------------------
// global_types
//   Types shared across the datapath and memory subsystem.
//   - logic10 / logic32 : word-address and data-word shorthands.
//   - dmem_owner_t      : which port owns the data memory in a cycle.
//   - HOLD_W            : width of the data-memory burst-hold counter.
//   - hold_sat_inc()    : saturating increment for that counter.
// -----------------------------------------------------------------------------
package global_types;

    typedef logic [9:0]  logic10;
    typedef logic [31:0] logic32;

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} dmem_owner_t;

    localparam int HOLD_W = 4;

    // Count up by one, never past the limit.
    function automatic logic [HOLD_W-1:0] hold_sat_inc(
        input logic [HOLD_W-1:0] cnt,
        input logic [HOLD_W-1:0] limit
    );
        return (cnt < limit) ? cnt + 1'b1 : limit;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the CPU load/store port and
//   the debug/DMA port. At most one port is granted per cycle; the granted
//   port drives the memory address/write-data/write-enable, and read data is
//   flagged valid to that port one cycle later. A burst-hold counter lets the
//   current owner stream up to MAX_HOLD accesses before yielding to a waiting
//   port. cpu_gnt low is the CPU's memory stall.
//
// Parameters
//   ADDR_W   : word address width
//   DATA_W   : data width
//   MAX_HOLD : consecutive grants to one owner under contention (1..15)
//
// Ports
//   clock, reset_n                        : clock, async active-low reset
//   cpu_req/we/addr/wd  -> cpu_gnt        : CPU request, same-cycle grant
//   cpu_rvalid, cpu_rd                    : CPU read return
//   dbg_req/we/addr/wd  -> dbg_gnt        : debug request, same-cycle grant
//   dbg_rvalid, dbg_rd                    : debug read return
//   mem_we, mem_addr, mem_wd              : memory command (from granted port)
//   mem_rd                                : memory read data (sync, 1 cycle)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import global_types::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rd,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wd,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rd,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("dmem_arbiter: MAX_HOLD must be in 1..15");
    end

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    // State
    dmem_owner_t       r_owner;
    dmem_owner_t       r_last;
    logic [HOLD_W-1:0] r_hold_cnt;
    dmem_owner_t       r_rsel;

    // Decision
    logic        w_cpu_win;
    logic        w_dbg_win;
    logic        w_cpu_gnt;
    logic        w_dbg_gnt;
    logic        w_any_gnt;
    logic        w_gnt_we;
    dmem_owner_t w_gnt_owner;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_cpu_win = 1'b0;
        w_dbg_win = 1'b0;
        if (cpu_req && dbg_req) begin
            if (r_owner != OWN_NONE && r_hold_cnt < HOLD_MAX) begin
                // Owner still inside its burst allowance keeps the memory.
                w_cpu_win = (r_owner == OWN_CPU);
                w_dbg_win = (r_owner == OWN_DBG);
            end else begin
                // Allowance used up (or nobody owns it): the port that did
                // not go last wins.
                w_cpu_win = (r_last != OWN_CPU);
                w_dbg_win = (r_last == OWN_CPU);
            end
        end else begin
            w_cpu_win = cpu_req;
            w_dbg_win = dbg_req;
        end
    end

    // Grants are suppressed while reset is asserted so no write can reach
    // the memory during reset.
    assign w_cpu_gnt = w_cpu_win & reset_n;
    assign w_dbg_gnt = w_dbg_win & reset_n;
    assign w_any_gnt = w_cpu_gnt | w_dbg_gnt;

    always_comb begin
        w_gnt_owner = OWN_NONE;
        if (w_cpu_gnt) begin
            w_gnt_owner = OWN_CPU;
        end else if (w_dbg_gnt) begin
            w_gnt_owner = OWN_DBG;
        end
    end

    assign w_gnt_we = w_dbg_gnt ? dbg_we : cpu_we;

    // Memory command: debug fields only when debug holds the grant, the CPU
    // fields otherwise (including the idle case).
    assign mem_addr = w_dbg_gnt ? dbg_addr : cpu_addr;
    assign mem_wd   = w_dbg_gnt ? dbg_wd   : cpu_wd;
    assign mem_we   = w_any_gnt & w_gnt_we;

    assign cpu_gnt = w_cpu_gnt;
    assign dbg_gnt = w_dbg_gnt;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_owner    <= OWN_NONE;
            r_last     <= OWN_DBG;   // CPU wins the first tie after reset
            r_hold_cnt <= '0;
            r_rsel     <= OWN_NONE;
        end else if (w_any_gnt) begin
            r_owner    <= w_gnt_owner;
            r_last     <= w_gnt_owner;
            r_hold_cnt <= (w_gnt_owner == r_owner) ? hold_sat_inc(r_hold_cnt, HOLD_MAX)
                                                   : HOLD_W'(1);
            r_rsel     <= w_gnt_we ? OWN_NONE : w_gnt_owner;
        end else begin
            // An idle cycle drops ownership; the next tie uses r_last only.
            r_owner    <= OWN_NONE;
            r_hold_cnt <= '0;
            r_rsel     <= OWN_NONE;
        end
    end

    // Read return: the memory's data is broadcast, r_rsel says whose it is.
    assign cpu_rvalid = (r_rsel == OWN_CPU);
    assign dbg_rvalid = (r_rsel == OWN_DBG);
    assign cpu_rd     = mem_rd;
    assign dbg_rd     = mem_rd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Two arbiters (MAX_HOLD = 4 and MAX_HOLD = 1) share the same port stimulus,
//   each backed by its own synchronous write-first memory. Unwritten words
//   read as 32'hA500_0000 | address.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;

    logic              cpu_req  = 1'b0;
    logic              cpu_we   = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wd   = '0;
    logic              dbg_req  = 1'b0;
    logic              dbg_we   = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wd   = '0;

    // MAX_HOLD = 4 instance
    logic              cpu_gnt4, cpu_rvalid4, dbg_gnt4, dbg_rvalid4, mem_we4;
    logic [DATA_W-1:0] cpu_rd4, dbg_rd4, mem_wd4, mem_rd4;
    logic [ADDR_W-1:0] mem_addr4;
    // MAX_HOLD = 1 instance
    logic              cpu_gnt1, cpu_rvalid1, dbg_gnt1, dbg_rvalid1, mem_we1;
    logic [DATA_W-1:0] cpu_rd1, dbg_rd1, mem_wd1, mem_rd1;
    logic [ADDR_W-1:0] mem_addr1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)) u_arb4 (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_gnt(cpu_gnt4), .cpu_rvalid(cpu_rvalid4), .cpu_rd(cpu_rd4),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
        .dbg_gnt(dbg_gnt4), .dbg_rvalid(dbg_rvalid4), .dbg_rd(dbg_rd4),
        .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wd(mem_wd4), .mem_rd(mem_rd4)
    );

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(1)) u_arb1 (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1), .cpu_rd(cpu_rd1),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
        .dbg_gnt(dbg_gnt1), .dbg_rvalid(dbg_rvalid1), .dbg_rd(dbg_rd1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wd(mem_wd1), .mem_rd(mem_rd1)
    );

    // Synchronous write-first memories, filled with a known pattern on the
    // first clock edge (which falls inside the initial reset).
    logic [DATA_W-1:0] mem4 [1024];
    logic [DATA_W-1:0] mem1 [1024];
    bit                mem_init = 1'b0;

    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem4[i] <= 32'hA500_0000 | i;
                mem1[i] <= 32'hA500_0000 | i;
            end
            mem_rd4  <= '0;
            mem_rd1  <= '0;
            mem_init <= 1'b1;
        end else begin
            if (mem_we4) begin
                mem4[mem_addr4] <= mem_wd4;
                mem_rd4         <= mem_wd4;
            end else begin
                mem_rd4 <= mem4[mem_addr4];
            end
            if (mem_we1) begin
                mem1[mem_addr1] <= mem_wd1;
                mem_rd1         <= mem_wd1;
            end else begin
                mem_rd1 <= mem1[mem_addr1];
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit
    // later, well clear of the next edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_ports();
        cpu_req = 1'b0; cpu_we = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0;
    endtask

    task automatic do_reset();
        idle_ports();
        reset_n = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        cpu_req  = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h001; cpu_wd = 32'h1111_1111;
        dbg_req  = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h002; dbg_wd = 32'h2222_2222;
        @(posedge clock);
        #2;
        n_checks++;
        if ({cpu_gnt4, dbg_gnt4, mem_we4} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_grants4: got gnt/we %b exp 000", {cpu_gnt4, dbg_gnt4, mem_we4});
        end
        n_checks++;
        if ({cpu_rvalid4, dbg_rvalid4} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_rvalid4: got %b exp 00", {cpu_rvalid4, dbg_rvalid4});
        end
        n_checks++;
        if ({cpu_gnt1, dbg_gnt1, mem_we1, cpu_rvalid1, dbg_rvalid1} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_outputs1: got %b exp 00000",
                     {cpu_gnt1, dbg_gnt1, mem_we1, cpu_rvalid1, dbg_rvalid1});
        end
        next_cycle();
        idle_ports();
        reset_n = 1'b1;
    endtask

    task automatic test_cpu_store_load();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h1F0; cpu_wd = 32'h0000_003C;
        #1;
        n_checks++;
        if ({cpu_gnt4, dbg_gnt4, mem_we4} !== 3'b101) begin
            n_fail++;
            $display("FAIL store_gnt_we: got %b exp 101", {cpu_gnt4, dbg_gnt4, mem_we4});
        end
        n_checks++;
        if (mem_addr4 !== 10'h1F0 || mem_wd4 !== 32'h3C) begin
            n_fail++;
            $display("FAIL store_cmd: got addr %h wd %h exp 1f0 0000003c", mem_addr4, mem_wd4);
        end
        next_cycle();
        cpu_we = 1'b0;
        #1;
        n_checks++;
        if ({cpu_gnt4, mem_we4, cpu_rvalid4} !== 3'b100) begin
            n_fail++;
            $display("FAIL load_issue: got gnt/we/rvalid %b exp 100", {cpu_gnt4, mem_we4, cpu_rvalid4});
        end
        next_cycle();
        // CPU idle but with we asserted: no grant means no write.
        cpu_req = 1'b0; cpu_we = 1'b1;
        #1;
        n_checks++;
        if ({cpu_rvalid4, dbg_rvalid4} !== 2'b10 || cpu_rd4 !== 32'h3C) begin
            n_fail++;
            $display("FAIL load_return: got rvalid %b rd %h exp 10 0000003c",
                     {cpu_rvalid4, dbg_rvalid4}, cpu_rd4);
        end
        n_checks++;
        if ({cpu_gnt4, mem_we4} !== 2'b00 || mem_addr4 !== 10'h1F0) begin
            n_fail++;
            $display("FAIL idle_cmd: got gnt/we %b addr %h exp 00 1f0", {cpu_gnt4, mem_we4}, mem_addr4);
        end
        next_cycle();
        cpu_we = 1'b0;
        #1;
        n_checks++;
        if (cpu_rvalid4 !== 1'b0) begin
            n_fail++;
            $display("FAIL rvalid_one_cycle: got %b exp 0", cpu_rvalid4);
        end
    endtask

    task automatic test_back_to_back();
        // Debug writes, CPU reads the same word on the very next cycle.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h3FF; dbg_wd = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({cpu_gnt4, dbg_gnt4, mem_we4} !== 3'b011 || mem_addr4 !== 10'h3FF
            || mem_wd4 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL dbg_write: got gnt/we %b addr %h wd %h exp 011 3ff deadbeef",
                     {cpu_gnt4, dbg_gnt4, mem_we4}, mem_addr4, mem_wd4);
        end
        next_cycle();
        dbg_req = 1'b0; dbg_we = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
        #1;
        n_checks++;
        if ({cpu_gnt4, dbg_rvalid4, mem_we4} !== 3'b100 || mem_addr4 !== 10'h3FF) begin
            n_fail++;
            $display("FAIL b2b_read_issue: got gnt/rvalid/we %b addr %h exp 100 3ff",
                     {cpu_gnt4, dbg_rvalid4, mem_we4}, mem_addr4);
        end
        next_cycle();
        cpu_req = 1'b0;
        #1;
        n_checks++;
        if (cpu_rvalid4 !== 1'b1 || cpu_rd4 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL b2b_read_data: got rvalid %b rd %h exp 1 deadbeef", cpu_rvalid4, cpu_rd4);
        end
        next_cycle();
    endtask

    task automatic test_tie_after_reset();
        logic exp_c;
        logic prev_c;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h001;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h002;
        prev_c = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_c = (k < 4) || (k >= 8);
            #1;
            n_checks++;
            if ({cpu_gnt4, dbg_gnt4} !== {exp_c, ~exp_c}
                || mem_addr4 !== (exp_c ? 10'h001 : 10'h002)) begin
                n_fail++;
                $display("FAIL tie_grant cycle %0d: got gnt %b addr %h exp %b %h", k,
                         {cpu_gnt4, dbg_gnt4}, mem_addr4, {exp_c, ~exp_c},
                         exp_c ? 10'h001 : 10'h002);
            end
            if (k > 0) begin
                n_checks++;
                if ({cpu_rvalid4, dbg_rvalid4} !== {prev_c, ~prev_c}
                    || cpu_rd4 !== (prev_c ? 32'hA500_0001 : 32'hA500_0002)) begin
                    n_fail++;
                    $display("FAIL tie_return cycle %0d: got rvalid %b rd %h exp %b %h", k,
                             {cpu_rvalid4, dbg_rvalid4}, cpu_rd4, {prev_c, ~prev_c},
                             prev_c ? 32'hA500_0001 : 32'hA500_0002);
                end
            end
            prev_c = exp_c;
            next_cycle();
        end
        idle_ports();
    endtask

    task automatic test_alternation();
        logic exp_c;
        logic prev_c;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h006;
        prev_c = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp_c = (k % 2) == 0;
            #1;
            n_checks++;
            if ({cpu_gnt1, dbg_gnt1} !== {exp_c, ~exp_c}) begin
                n_fail++;
                $display("FAIL alt_grant cycle %0d: got %b exp %b", k,
                         {cpu_gnt1, dbg_gnt1}, {exp_c, ~exp_c});
            end
            if (k > 0) begin
                n_checks++;
                if ({cpu_rvalid1, dbg_rvalid1} !== {prev_c, ~prev_c}
                    || dbg_rd1 !== (prev_c ? 32'hA500_0005 : 32'hA500_0006)) begin
                    n_fail++;
                    $display("FAIL alt_return cycle %0d: got rvalid %b rd %h exp %b %h", k,
                             {cpu_rvalid1, dbg_rvalid1}, dbg_rd1, {prev_c, ~prev_c},
                             prev_c ? 32'hA500_0005 : 32'hA500_0006);
                end
            end
            prev_c = exp_c;
            next_cycle();
        end
        idle_ports();
    endtask

    task automatic test_idle_gap();
        logic exp_c4;
        logic exp_c1;
        do_reset();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h010;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if ({cpu_gnt4, dbg_gnt4, cpu_gnt1, dbg_gnt1} !== 4'b0101) begin
                n_fail++;
                $display("FAIL gap_dbg_solo cycle %0d: got %b exp 0101", k,
                         {cpu_gnt4, dbg_gnt4, cpu_gnt1, dbg_gnt1});
            end
            next_cycle();
        end
        dbg_req = 1'b0;
        #1;
        n_checks++;
        if ({cpu_gnt4, dbg_gnt4, cpu_gnt1, dbg_gnt1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL gap_idle: got %b exp 0000", {cpu_gnt4, dbg_gnt4, cpu_gnt1, dbg_gnt1});
        end
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h011;
        dbg_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_c4 = (k < 4);
            exp_c1 = (k % 2) == 0;
            #1;
            n_checks++;
            if ({cpu_gnt4, dbg_gnt4, cpu_gnt1, dbg_gnt1} !== {exp_c4, ~exp_c4, exp_c1, ~exp_c1}) begin
                n_fail++;
                $display("FAIL gap_tie cycle %0d: got %b exp %b", k,
                         {cpu_gnt4, dbg_gnt4, cpu_gnt1, dbg_gnt1},
                         {exp_c4, ~exp_c4, exp_c1, ~exp_c1});
            end
            next_cycle();
        end
        idle_ports();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h020;
        #1;
        n_checks++;
        if ({cpu_gnt4, dbg_gnt4} !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_issue: got %b exp 01", {cpu_gnt4, dbg_gnt4});
        end
        next_cycle();
        // The read's return cycle: reset lands, and a write is requested.
        reset_n = 1'b0;
        dbg_we  = 1'b1; dbg_wd = 32'h0BAD_0BAD;
        #1;
        n_checks++;
        if ({dbg_rvalid4, dbg_rvalid1, dbg_gnt4, mem_we4, mem_we1} !== 5'b00000) begin
            n_fail++;
            $display("FAIL midrst_in_reset: got rvalid4/rvalid1/gnt4/we4/we1 %b exp 00000",
                     {dbg_rvalid4, dbg_rvalid1, dbg_gnt4, mem_we4, mem_we1});
        end
        next_cycle();
        n_checks++;
        if ({dbg_rvalid4, mem_we4} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_held: got rvalid/we %b exp 00", {dbg_rvalid4, mem_we4});
        end
        reset_n = 1'b1;
        dbg_we  = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h021;
        #1;
        n_checks++;
        if ({cpu_gnt4, dbg_gnt4, cpu_gnt1, dbg_gnt1} !== 4'b1010) begin
            n_fail++;
            $display("FAIL midrst_resume: got %b exp 1010", {cpu_gnt4, dbg_gnt4, cpu_gnt1, dbg_gnt1});
        end
        next_cycle();
        idle_ports();
        #1;
        n_checks++;
        if ({cpu_rvalid4, dbg_rvalid4} !== 2'b10 || cpu_rd4 !== 32'hA500_0021) begin
            n_fail++;
            $display("FAIL midrst_after_read: got rvalid %b rd %h exp 10 a5000021",
                     {cpu_rvalid4, dbg_rvalid4}, cpu_rd4);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_cpu_store_load();
        test_back_to_back();
        test_tie_after_reset();
        test_alternation();
        test_idle_gap();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
